acc_cpu_core: RTL
=================

// Module: acc_cpu_core
// PURPOSE
//  Parametrised 8-bit accumulator CPU, 6502-opcode subset, successor to the single-path fetch core.
//  Decodes opcodes, supports immediate/absolute modes, ALU with flags, memory writes, jumps and halt.
//  Sits on the shared single-port RAM bus (async-read, posedge-write) in the example SoC top.
// PARAMETERS
//  ADDR_W     16       address/PC width, legal 12..16; absolute operands use {adh,adl}[ADDR_W-1:0]
//  RESET_VEC  'h0000   PC and addr value loaded at reset (ADDR_W bits)
// PORTS
//  clk     in   1       system clock, all state on posedge
//  reset   in   1       asynchronous, active-low reset
//  addr    out  ADDR_W  registered bus address
//  data    inout 8      driven with A only when rw=0, else 'bz; sampled on posedge when rw=1
//  rw      out  1       1=read, 0=write (combinational from state)
//  sync    out  1       1 while in FETCH (opcode cycle)
//  halted  out  1       1 in HALT state
// BEHAVIOUR
//  Reset (async, reset=0): pc=addr=RESET_VEC, A=0, C=Z=N=0, state=FETCH, rw=1, sync=1, halted=0.
//  Bus: data valid for current addr within the cycle; CPU latches it at posedge ending that cycle.
//  States: FETCH, OPR_LO, OPR_HI, MEM_RD, MEM_WR, BR_ADJ, HALT.
//  FETCH: latch opcode, pc<=pc+1, addr<=pc+1; unknown opcode -> HALT (addr holds), else OPR_LO.
//  Opcodes / cycles (FETCH counted):
//   A9 LDA #imm 2: OPR_LO A<=data, Z/N update.        69 ADC #imm 2: A<=A+data+C.
//   AD LDA abs  4: OPR_LO adl, OPR_HI adh, MEM_RD.    6D ADC abs  4: same path, add in MEM_RD.
//   8D STA abs  4: MEM_WR: addr={adh,adl}, rw=0, data=A; flags unchanged.
//   4C JMP abs  3: OPR_HI pc<={data,adl}, addr<=same, -> FETCH.
//   18 CLC / 38 SEC / EA NOP 2: OPR_LO is dummy read of pc (pc not incremented), C updated.
//  Operand cycles (OPR_LO/OPR_HI) read addr=pc then pc<=pc+1; MEM_RD/MEM_WR leave pc unchanged.
//  After MEM_RD/MEM_WR/last operand cycle: addr<=pc, state<=FETCH.
//  ALU: 9-bit sum {C,A}<=A+M+C; Z=(A==0); N=A[7]; LDA updates Z/N only; no decimal, no V.
//  PC arithmetic wraps modulo 2^ADDR_W (pc=all-ones +1 -> 0).
//  HALT: rw=1, halted=1, addr frozen; exits only via reset.
//  rw=0 only during MEM_WR; data released to 'bz combinationally when state leaves MEM_WR.
//  Reset mid-operation (incl. MEM_WR) forces rw=1 and data='bz immediately (async).
// CONFIGURATION
//  CPU_BRANCH_EN defined: F0 BEQ rel, D0 BNE rel. OPR_LO reads signed offset, pc<=pc+1;
//   not taken -> FETCH (2 cycles); taken -> BR_ADJ: pc<=pc+sext(off) mod 2^ADDR_W,
//   addr<=new pc, -> FETCH (3 cycles). Offset is relative to address after operand.
//  CPU_BRANCH_EN undefined: F0/D0 are unknown opcodes -> HALT; BR_ADJ state absent.
// TESTING
//  1 reset; RAM 0:A9 42 8D 00 02 -> cycle 6 rw=0 addr=0x0200 data=0x42; RAM[0x200]=0x42.
//  2 A9 FF 69 01 -> A=0x00, C=1, Z=1, N=0; then 69 00 -> A=0x01, C=0, Z=0.
//  3 4C 34 12 at 0x0000 -> sync=1 with addr=0x1234 exactly 3 cycles after reset release.
//  4 opcode 0x02 at 0x0000 -> halted=1 after 1 cycle, addr=0x0001 held, rw=1 for 100 cycles.
//  5 reset=0 asserted mid-cycle during STA MEM_WR -> rw=1, data='bz, addr=RESET_VEC same cycle.
//  6 CPU_BRANCH_EN: A9 00 F0 FC -> BEQ taken, loops to 0x0000 every 5 cycles; no macro: halted=1.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core
// 8-bit accumulator CPU that executes a subset of the 6502 opcodes on a shared
// single-port RAM bus (async read, posedge write), one bus access per clock.
// Optional feature: define CPU_BRANCH_EN to add BEQ (F0) and BNE (D0) relative
// branches. Without it, those opcodes halt like any other unknown opcode.
module acc_cpu_core #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [7:0]        data,
    output logic              rw,
    output logic              sync,
    output logic              halted
);

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_ADC_ABS = 8'h6D;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;
`ifdef CPU_BRANCH_EN
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_BNE     = 8'hD0;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_OPR_LO = 3'd1,
        S_OPR_HI = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
`ifdef CPU_BRANCH_EN
        S_BR_ADJ = 3'd5,
`endif
        S_HALT   = 3'd6
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        acc;
    logic              c, z, n;
    logic [7:0]        opcode;
    logic [7:0]        adl;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] abs_addr;
    logic [8:0]        sum;
`ifdef CPU_BRANCH_EN
    logic signed [7:0] off;
    logic [ADDR_W-1:0] br_target;
`endif

    // 9-bit add with carry in; bit 8 is the carry out.
    function automatic logic [8:0] adc9(input logic [7:0] x, input logic [7:0] m,
                                        input logic ci);
        adc9 = {1'b0, x} + {1'b0, m} + {8'd0, ci};
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_ADC_IMM, OP_LDA_ABS, OP_ADC_ABS,
            OP_STA_ABS, OP_JMP_ABS, OP_CLC, OP_SEC, OP_NOP: op_known = 1'b1;
`ifdef CPU_BRANCH_EN
            OP_BEQ, OP_BNE: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    endfunction

    assign pc_inc   = pc + ADDR_W'(1);
    assign abs_addr = ADDR_W'({data, adl});
    assign sum      = adc9(acc, data, c);
`ifdef CPU_BRANCH_EN
    // Offset is signed; the size cast sign-extends it to the PC width.
    assign br_target = pc + ADDR_W'(off);
`endif

    assign rw     = (state != S_MEM_WR);
    assign sync   = (state == S_FETCH);
    assign halted = (state == S_HALT);
    assign data   = rw ? 8'hzz : acc;

    // Opcode and operand holding registers: pure datapath, never need a reset value.
    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            opcode <= data;
        end
        if (state == S_OPR_LO) begin
            adl <= data;
`ifdef CPU_BRANCH_EN
            off <= data;
`endif
        end
    end

    // Instruction sequencer: one state per bus cycle, with PC, address, A and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= RESET_VEC;
            addr  <= RESET_VEC;
            acc   <= 8'h00;
            c     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    pc    <= pc_inc;
                    addr  <= pc_inc;
                    state <= op_known(data) ? S_OPR_LO : S_HALT;
                end
                S_OPR_LO: begin
                    case (opcode)
                        OP_LDA_IMM: begin
                            acc   <= data;
                            z     <= (data == 8'h00);
                            n     <= data[7];
                            pc    <= pc_inc;
                            addr  <= pc_inc;
                            state <= S_FETCH;
                        end
                        OP_ADC_IMM: begin
                            {c, acc} <= sum;
                            z        <= (sum[7:0] == 8'h00);
                            n        <= sum[7];
                            pc       <= pc_inc;
                            addr     <= pc_inc;
                            state    <= S_FETCH;
                        end
                        OP_LDA_ABS, OP_ADC_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                            pc    <= pc_inc;
                            addr  <= pc_inc;
                            state <= S_OPR_HI;
                        end
                        // Implied opcodes: the operand cycle is a dummy read, PC stays put.
                        OP_CLC: begin
                            c     <= 1'b0;
                            addr  <= pc;
                            state <= S_FETCH;
                        end
                        OP_SEC: begin
                            c     <= 1'b1;
                            addr  <= pc;
                            state <= S_FETCH;
                        end
                        OP_NOP: begin
                            addr  <= pc;
                            state <= S_FETCH;
                        end
`ifdef CPU_BRANCH_EN
                        OP_BEQ, OP_BNE: begin
                            pc    <= pc_inc;
                            addr  <= pc_inc;
                            state <= ((opcode == OP_BEQ) == z) ? S_BR_ADJ : S_FETCH;
                        end
`endif
                        default: state <= S_HALT;
                    endcase
                end
                S_OPR_HI: begin
                    case (opcode)
                        OP_JMP_ABS: begin
                            pc    <= abs_addr;
                            addr  <= abs_addr;
                            state <= S_FETCH;
                        end
                        OP_STA_ABS: begin
                            pc    <= pc_inc;
                            addr  <= abs_addr;
                            state <= S_MEM_WR;
                        end
                        OP_LDA_ABS, OP_ADC_ABS: begin
                            pc    <= pc_inc;
                            addr  <= abs_addr;
                            state <= S_MEM_RD;
                        end
                        default: state <= S_HALT;
                    endcase
                end
                S_MEM_RD: begin
                    if (opcode == OP_ADC_ABS) begin
                        {c, acc} <= sum;
                        z        <= (sum[7:0] == 8'h00);
                        n        <= sum[7];
                    end else begin
                        acc <= data;
                        z   <= (data == 8'h00);
                        n   <= data[7];
                    end
                    addr  <= pc;
                    state <= S_FETCH;
                end
                S_MEM_WR: begin
                    addr  <= pc;
                    state <= S_FETCH;
                end
`ifdef CPU_BRANCH_EN
                S_BR_ADJ: begin
                    pc    <= br_target;
                    addr  <= br_target;
                    state <= S_FETCH;
                end
`endif
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
